// File: rtl/vc_pop_arbiter.sv
// Two-VC pop scheduler: VC0 has fixed priority, and a burst limit guarantees VC1 forward progress.
// Routes each popped head word to destination D0 or D1, chosen by the word's MSB, with one cycle of latency.
module vc_pop_arbiter #(
  parameter int DATA_SIZE = 6,
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vc0_empty,
  input  logic                 vc1_empty,
  input  logic [DATA_SIZE-1:0] vc0_data,
  input  logic [DATA_SIZE-1:0] vc1_data,
  input  logic                 d0_almost_full,
  input  logic                 d1_almost_full,
  output logic                 pop_vc0,
  output logic                 pop_vc1,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 push_d0,
  output logic                 push_d1,
  output logic                 idle,
  output logic [CNT_W-1:0]     burst_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_GNT0, S_GNT1} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DATA_SIZE-1:0] r_data;
  logic                 r_push_d0;
  logic                 r_push_d1;
  logic                 r_idle;
  logic [CNT_W-1:0]     r_burst_cnt;

  logic                 w_elig0;
  logic                 w_elig1;
  logic                 w_cnt_max;
  logic                 w_gnt0;
  logic                 w_gnt1;
  logic                 w_idle_nxt;
  logic [DATA_SIZE-1:0] w_gnt_word;

  // A VC is eligible only when its head word's own destination can accept it,
  // so a full destination never blocks the other VC.
  assign w_elig0 = !vc0_empty &&
                   !(vc0_data[DATA_SIZE-1] ? d1_almost_full : d0_almost_full);
  assign w_elig1 = !vc1_empty &&
                   !(vc1_data[DATA_SIZE-1] ? d1_almost_full : d0_almost_full);

  assign w_cnt_max = (r_burst_cnt == CNT_W'(BURST_MAX));

  // Reset also gates the grants, so the pops drop immediately, with no wait for an edge.
  assign w_gnt1 = !reset && w_elig1 && (!w_elig0 || w_cnt_max);
  assign w_gnt0 = !reset && w_elig0 && !w_gnt1;

  assign pop_vc0 = w_gnt0;
  assign pop_vc1 = w_gnt1;

  assign w_gnt_word = w_gnt1 ? vc1_data : vc0_data;

  // Burst counter: counts VC0 grants only while VC1 is waiting on them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_burst_cnt <= '0;
    end else if (w_gnt0 && w_elig1) begin
      r_burst_cnt <= r_burst_cnt + CNT_W'(1);
    end else if (w_gnt1 || !w_elig1) begin
      r_burst_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data    <= '0;
      r_push_d0 <= 1'b0;
      r_push_d1 <= 1'b0;
    end else begin
      r_push_d0 <= 1'b0;
      r_push_d1 <= 1'b0;
      if (w_gnt0 || w_gnt1) begin
        r_data    <= w_gnt_word;
        r_push_d0 <= !w_gnt_word[DATA_SIZE-1];
        r_push_d1 <=  w_gnt_word[DATA_SIZE-1];
      end
    end
  end

  // Last-grant tracker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idle  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_idle  <= w_idle_nxt;
    end
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    if (w_gnt0) begin
      w_state_nxt = S_GNT0;
    end else if (w_gnt1) begin
      w_state_nxt = S_GNT1;
    end
    w_idle_nxt = (w_state_nxt == S_IDLE) && vc0_empty && vc1_empty;
  end

  // The state register records whether the previous cycle issued a grant.
  // It must agree with the push strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ((r_state != S_IDLE) == (r_push_d0 || r_push_d1))
        else $error("push strobes disagree with grant tracker");
    end
  end

  assign data_out  = r_data;
  assign push_d0   = r_push_d0;
  assign push_d1   = r_push_d1;
  assign idle      = r_idle;
  assign burst_cnt = r_burst_cnt;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed bench for vc_pop_arbiter.
// Stimulus queues the expected pushed words, and a monitor pops and compares them on every push strobe.
module tb_vc_pop_arbiter;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vc0_empty = 1'b1, vc1_empty = 1'b1;
  logic [DW-1:0] vc0_data = '0, vc1_data = '0;
  logic          d0_almost_full = 1'b0, d1_almost_full = 1'b0;
  logic          pop_vc0, pop_vc1, push_d0, push_d1, idle;
  logic [DW-1:0] data_out;
  logic [2:0]    burst_cnt;

  logic [DW-1:0] sbq[$];
  int            n_checks = 0;
  int            n_errors = 0;

  vc_pop_arbiter #(.DATA_SIZE(DW), .BURST_MAX(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .data_out(data_out), .push_d0(push_d0), .push_d1(push_d1),
    .idle(idle), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each push strobe consumes one queued expected word.
  always @(posedge clk) begin
    logic [DW-1:0] w;
    #1;
    if (push_d0 || push_d1) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected_push: got data %0h d0 %0b d1 %0b expected no push",
                 data_out, push_d0, push_d1);
      end else begin
        w = sbq.pop_front();
        chk("sb_data", 32'(data_out), 32'(w));
        chk("sb_push_d0", 32'(push_d0), 32'(!w[DW-1]));
        chk("sb_push_d1", 32'(push_d1), 32'(w[DW-1]));
      end
    end
  end

  // One cycle.
  // Inputs are driven at the negedge, and the pops are checked before the edge.
  // Counter and idle are checked after the edge.
  task automatic cyc(input string name, input logic e0, input logic e1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                     input logic af0, input logic af1,
                     input logic xp0, input logic xp1,
                     input logic [2:0] xcnt, input logic xidle);
    @(negedge clk);
    vc0_empty = e0; vc1_empty = e1; vc0_data = d0; vc1_data = d1;
    d0_almost_full = af0; d1_almost_full = af1;
    #1;
    chk({name, "/pop_vc0"}, 32'(pop_vc0), 32'(xp0));
    chk({name, "/pop_vc1"}, 32'(pop_vc1), 32'(xp1));
    if (xp0) sbq.push_back(d0);
    if (xp1) sbq.push_back(d1);
    @(posedge clk);
    #2;
    chk({name, "/burst_cnt"}, 32'(burst_cnt), 32'(xcnt));
    chk({name, "/idle"}, 32'(idle), 32'(xidle));
  endtask

  initial begin
    #12;
    chk("rst/pop_vc0", 32'(pop_vc0), 0);
    chk("rst/pop_vc1", 32'(pop_vc1), 0);
    chk("rst/push_d0", 32'(push_d0), 0);
    chk("rst/push_d1", 32'(push_d1), 0);
    chk("rst/data_out", 32'(data_out), 0);
    chk("rst/idle", 32'(idle), 1);
    chk("rst/burst_cnt", 32'(burst_cnt), 0);
    @(negedge clk);
    reset = 1'b0;

    cyc("empty", 1, 1, 6'h00, 6'h00, 0, 0, 0, 0, 3'd0, 1);

    // VC0 alone sends three words. Their destinations are D0, D1, D0.
    cyc("vc0_a", 0, 1, 6'h05, 6'h00, 0, 0, 1, 0, 3'd0, 0);
    cyc("vc0_b", 0, 1, 6'h21, 6'h00, 0, 0, 1, 0, 3'd0, 0);
    cyc("vc0_c", 0, 1, 6'h0A, 6'h00, 0, 0, 1, 0, 3'd0, 0);
    cyc("vc0_e", 1, 1, 6'h0A, 6'h00, 0, 0, 0, 0, 3'd0, 1);

    // Both VCs are busy. The expected grant pattern is 0,0,0,0,1,0,0,0,0,1.
    cyc("bst1", 0, 0, 6'h01, 6'h11, 0, 0, 1, 0, 3'd1, 0);
    cyc("bst2", 0, 0, 6'h02, 6'h11, 0, 0, 1, 0, 3'd2, 0);
    cyc("bst3", 0, 0, 6'h03, 6'h11, 0, 0, 1, 0, 3'd3, 0);
    cyc("bst4", 0, 0, 6'h04, 6'h11, 0, 0, 1, 0, 3'd4, 0);
    cyc("bst5", 0, 0, 6'h05, 6'h11, 0, 0, 0, 1, 3'd0, 0);
    cyc("bst6", 0, 0, 6'h05, 6'h12, 0, 0, 1, 0, 3'd1, 0);
    cyc("bst7", 0, 0, 6'h06, 6'h12, 0, 0, 1, 0, 3'd2, 0);
    cyc("bst8", 0, 0, 6'h07, 6'h12, 0, 0, 1, 0, 3'd3, 0);
    cyc("bst9", 0, 0, 6'h08, 6'h12, 0, 0, 1, 0, 3'd4, 0);
    cyc("bst10", 0, 0, 6'h09, 6'h12, 0, 0, 0, 1, 3'd0, 0);

    // The VC0 head targets a full D1, so VC1 passes it and goes to D0.
    cyc("hol", 0, 0, 6'h20, 6'h03, 0, 1, 0, 1, 3'd0, 0);

    // Both destinations are full, so nothing pops. After release, VC0 wins.
    cyc("bothaf1", 0, 0, 6'h01, 6'h22, 1, 1, 0, 0, 3'd0, 0);
    cyc("bothaf2", 0, 0, 6'h01, 6'h22, 1, 1, 0, 0, 3'd0, 0);
    cyc("release", 0, 0, 6'h01, 6'h22, 0, 0, 1, 0, 3'd1, 0);
    cyc("pre_rst", 0, 0, 6'h02, 6'h22, 0, 0, 1, 0, 3'd2, 0);
    chk("pre_rst/push_d0", 32'(push_d0), 1);

    // Asynchronous reset arrives mid-burst, between clock edges.
    #1;
    reset = 1'b1;
    #1;
    chk("arst/pop_vc0", 32'(pop_vc0), 0);
    chk("arst/pop_vc1", 32'(pop_vc1), 0);
    chk("arst/push_d0", 32'(push_d0), 0);
    chk("arst/data_out", 32'(data_out), 0);
    chk("arst/burst_cnt", 32'(burst_cnt), 0);
    chk("arst/idle", 32'(idle), 1);
    reset = 1'b0;
    cyc("post_rst", 0, 0, 6'h03, 6'h22, 0, 0, 1, 0, 3'd1, 0);
    cyc("drain", 1, 1, 6'h03, 6'h22, 0, 0, 0, 0, 3'd0, 1);
    chk("hold/data_out", 32'(data_out), 32'h03);
    chk("hold/push_d0", 32'(push_d0), 0);
    chk("sb_drain", 32'(sbq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vc_pop_arbiter.md
Name: vc_pop_arbiter

Overview:
- Schedules reads from the two virtual-channel FIFOs (VC0, VC1) and routes the popped word to one of two destination FIFOs (D0, D1).
- Generates the per-VC pop enables that drive the VC-select mux stage.
- Registers the selected word and the destination push strobes.
- VC0 has fixed priority, with a burst limit that guarantees VC1 forward progress.

Parameters:
- DATA_SIZE, 6, word width; bit DATA_SIZE-1 is the destination select (0 = D0, 1 = D1).
- BURST_MAX, 4, max consecutive VC0 grants while VC1 is eligible; range 1..2^CNT_W-1.
- CNT_W, 3, width of the burst counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- vc0_empty  input  1  VC0 FIFO empty
- vc1_empty  input  1  VC1 FIFO empty
- vc0_data  input  DATA_SIZE  VC0 head word (first-word-fall-through, valid when !vc0_empty)
- vc1_data  input  DATA_SIZE  VC1 head word
- d0_almost_full  input  1  D0 destination FIFO cannot accept another word
- d1_almost_full  input  1  D1 destination FIFO cannot accept another word
- pop_vc0  output  1  pop VC0 this cycle (combinational)
- pop_vc1  output  1  pop VC1 this cycle (combinational)
- data_out  output  DATA_SIZE  registered routed word
- push_d0  output  1  registered write strobe to D0
- push_d1  output  1  registered write strobe to D1
- idle  output  1  registered; no grant issued in the previous cycle and both VCs empty
- burst_cnt  output  CNT_W  current VC0 burst count (debug/observability)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. While reset=1:
  - pop_vc0 = pop_vc1 = 0, forced combinationally.
  - data_out = 0, push_d0 = push_d1 = 0.
  - burst_cnt = 0, state = IDLE, idle = 1.
- Eligibility (combinational):
  - elig0 = !vc0_empty && !(vc0_data[DATA_SIZE-1] ? d1_almost_full : d0_almost_full).
  - elig1 is the same form using vc1_*.
- Grant (combinational, single grant per cycle):
  - gnt1 = elig1 && (!elig0 || burst_cnt == BURST_MAX).
  - gnt0 = elig0 && !gnt1.
  - pop_vc0 = gnt0, pop_vc1 = gnt1.
  - pop_vc0 and pop_vc1 are never both 1.
- Burst counter, updated at the clock edge:
  - If gnt0 && elig1: burst_cnt + 1.
  - Else if gnt1 or !elig1: 0.
  - Otherwise: hold.
  - It never exceeds BURST_MAX.
- Datapath, 1-cycle latency:
  - On a grant, data_out <= granted head word; push_dX <= 1 for X = word[DATA_SIZE-1], and the other push <= 0.
  - With no grant, push_d0 = push_d1 = 0 next cycle and data_out holds its value.
- FSM (last-grant tracker), states IDLE, GNT0, GNT1:
  - Next state is GNT0 if gnt0, GNT1 if gnt1, otherwise IDLE.
  - idle <= (next state == IDLE) && vc0_empty && vc1_empty.
- Boundary conditions:
  - Almost-full is sampled only in the grant cycle. A destination asserting almost_full blocks only words headed to it; the other VC may still be granted (no head-of-line blocking across VCs).
  - Both almost_full = 1: no pops, counter holds or clears per the rules above.
  - Empty and head-word changes are handled combinationally in the same cycle; back-to-back grants to the same VC every cycle are legal.
  - If reset asserts mid-burst, all outputs clear immediately. After deassertion the first grant is evaluated on the next rising edge with burst_cnt = 0.

Test Plan:
- Reset, then vc0_empty = vc1_empty = 1 -> pops 0, push 0, data_out = 0, idle = 1, burst_cnt = 0.
- VC0 holds 3 words {6'h05, 6'h21, 6'h0A}, VC1 empty, no almost_full -> pop_vc0 high 3 cycles. One cycle later: push_d0, push_d1, push_d0 in turn, with data_out = 05, 21, 0A.
- Both VCs continuously non-empty, all heads dest 0, BURST_MAX = 4 -> grant pattern 0,0,0,0,1,0,0,0,0,1. burst_cnt runs 0..4 and resets after each VC1 grant.
- VC0 head 6'h20 (dest D1) with d1_almost_full = 1, VC1 head 6'h03 (dest D0) -> pop_vc1 = 1, pop_vc0 = 0; next cycle push_d0 = 1, data_out = 03.
- d0_almost_full = d1_almost_full = 1, both VCs non-empty -> no pops for the whole interval. On release, VC0 is granted first in the same cycle.
- Assert reset asynchronously mid-burst (burst_cnt = 2, push_d0 = 1) -> all outputs 0 before the next edge. After release with both VCs non-empty, the first grant is VC0 and burst_cnt = 1 after that edge.
